pi1_bram_slave: RTL and testbench
=================================

// Module: pi1_bram_slave
// PURPOSE
//  PI1 responder terminating a PI1 master port (e.g. a cache's downstream s_pi1_* side) on a
//  single-clock dual-port block RAM. Services write, read and atomic read-write (swap) ops with
//  byte selects. Optional programmable wait states exercise master back-pressure handling.
//  Used as on-chip RAM/ROM behind the cache hierarchy and as the standard bench memory model.
// PARAMETERS
//  ARCHBITSZ   32  data width in bits: 16/32/64/128; ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8)
//  SZ          1024  memory depth in words, power of 2, >=2
//  WAITCYCLES  0   extra cycles pi1_rdy_o is held low after each accepted op
//  INITFILE    ""  memory init file handed to bram SRCFILE; "" leaves contents uninitialised
// PORTS
//  clk_i       in   1               single clock, rising edge
//  rst_i       in   1               asynchronous, active-high reset
//  pi1_op_i    in   2               00 NOOP, 01 WR, 10 RD, 11 RW (swap)
//  pi1_addr_i  in   ADDRBITSZ       word address; only low clog2(SZ) bits used (aliasing)
//  pi1_data_i  in   ARCHBITSZ       write data for WR/RW
//  pi1_sel_i   in   ARCHBITSZ/8     byte enables for WR/RW; ignored for RD
//  pi1_data_o  out  ARCHBITSZ       read data of last RD/RW
//  pi1_rdy_o   out  1               responder ready / previous read data valid
// BEHAVIOUR
//  - Reset (async): state IDLE, pi1_rdy_o=1, pi1_data_o=0 (rdvalid flag cleared), wait counter=0.
//    Memory contents are not reset. Reset during WAIT/RMW aborts the op. If RMW is aborted,
//    the RW write is not performed.
//  - Accept: op!=NOOP && pi1_rdy_o at a rising edge. Inputs are sampled only at the accept edge.
//    NOOP never changes state. Inputs while rdy=0 are ignored.
//  - Read port: enabled only at the accept of RD/RW, so its output holds until the next RD/RW.
//    pi1_data_o = rdvalid ? ram_q : 0. rdvalid is set at the first accepted RD/RW.
//  - States: IDLE (rdy=1), RMW (rdy=0), WAIT (rdy=0, counter running).
//  - WR at edge N: bytes with sel=1 are written at edge N. sel=0 completes the handshake and writes nothing.
//    Next state: WAITCYCLES ? WAIT : IDLE.
//  - RD at edge N: word read at edge N; data valid in cycle N+1.
//    Next state: WAITCYCLES ? WAIT : IDLE. With W=0, back-to-back RDs run one per cycle.
//  - RW at edge N: old word read at edge N; next state RMW.
//    At edge N+1, (pi1_data_i_hold & selmask) | (ram_q & ~selmask) is written to the same address.
//    Next state: WAITCYCLES ? WAIT : IDLE. pi1_data_o = old word. Minimum rdy-low time is 1 cycle.
//  - WAIT: counter loaded with WAITCYCLES-1 on entry and decremented each cycle; IDLE on 0.
//    rdy stays low exactly WAITCYCLES cycles; pi1_data_o stays stable throughout.
//  - Master contract: read data is valid in the first cycle with rdy=1 after an RD/RW accept.
//    It remains valid until the next RD/RW accept.
//  - Write-port write and read-port read never target the same edge for one op.
//    Read-first/write-first behaviour is therefore irrelevant.
//  - Counter width is clog2(WAITCYCLES+1), minimum 1 bit; no wrap beyond load value.
// STRUCTURE
//  - PI1 op encodings (PINOOP/PIWROP/PIRDOP/PIRWOP) belong in the shared PI1 constants include,
//    not redeclared locally.
//  - One sub-module: lib/ram/bram (port0 read, en0=accept of RD/RW; port1 write).
//  - Hold registers for addr/data/sel, byte-mask expansion, FSM and wait counter are inline.
// TESTING
//  T1 W=0: WR a5 0xDEADBEEF sel 1111, then RD a5 -> rdy stays 1; data_o=0xDEADBEEF in cycle after RD.
//  T2 WR a5 0x000000AA sel 0001, then RD a5 -> data_o=0xDEADBEAA; WR sel 0000 leaves word unchanged.
//  T3 RW a5 0x12345678 sel 1111 -> rdy=0 exactly 1 cycle, data_o=0xDEADBEAA; RD a5 -> 0x12345678.
//  T4 W=3: RD a5 -> rdy=0 exactly 3 cycles; data_o stable; input toggling during wait has no effect.
//     A following WR keeps data_o unchanged.
//  T5 Assert rst_i during RMW, no clock edge -> rdy_o=1, data_o=0 immediately.
//     After release, RD returns the pre-RW word.
//  T6 SZ=16: WR addr 0x15 0xCAFEF00D, RD addr 0x05 -> 0xCAFEF00D (aliasing).
//     Back-to-back RDs a0,a1,a2 with W=0 return in consecutive cycles.

Source files
------------

// File: rtl/pi1_bram_slave_pkg.sv
// rtl/pi1_bram_slave_pkg.sv - PI1 op encodings, FSM states and sizing helpers
//
// Purpose: shared PI1 constants and types for the PI1 BRAM responder.
// Contents: pi1_op_e (NOOP/WR/RD/RW), state_e (IDLE/RMW/WAIT), cnt_width().
package pi1_bram_slave_pkg;

  typedef enum logic [1:0] {
    PINOOP = 2'b00,
    PIWROP = 2'b01,
    PIRDOP = 2'b10,
    PIRWOP = 2'b11
  } pi1_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RMW  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Wait counter must hold WAITCYCLES-1; keep at least one bit so the
  // counter exists even when no wait states are configured.
  function automatic int cnt_width(input int waitcycles);
    int w;
    w = $clog2(waitcycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pi1_bram_slave_if.sv
// rtl/pi1_bram_slave_if.sv - PI1 bus interface with master/slave modports
//
// Purpose: bundles the PI1 request/response signals between a master and a responder.
// Signals: pi1_op_i (2b op), pi1_addr_i (word address), pi1_data_i (write data),
//          pi1_sel_i (byte enables), pi1_data_o (read data), pi1_rdy_o (ready).
interface pi1_bram_slave_if #(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
);
  logic [1:0]             pi1_op_i;
  logic [ADDRBITSZ-1:0]   pi1_addr_i;
  logic [ARCHBITSZ-1:0]   pi1_data_i;
  logic [ARCHBITSZ/8-1:0] pi1_sel_i;
  logic [ARCHBITSZ-1:0]   pi1_data_o;
  logic                   pi1_rdy_o;

  modport master (
    output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    input  pi1_data_o, pi1_rdy_o
  );

  modport slave (
    input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    output pi1_data_o, pi1_rdy_o
  );
endinterface

// File: rtl/pi1_bram_slave_bram.sv
// rtl/pi1_bram_slave_bram.sv - single-clock dual-port block RAM, byte-writable
//
// Purpose: storage for the PI1 responder; port0 is a registered read port,
//          port1 a byte-enabled write port. Contents are never reset.
// Ports: clk_i; en0_i/addr0_i/q0_o (read); we1_i/addr1_i/d1_i/be1_i (write).
module pi1_bram_slave_bram #(
  parameter int DW = 32,
  parameter int SZ = 1024,
  parameter int AW = $clog2(SZ)
) (
  input  logic              clk_i,
  input  logic              en0_i,
  input  logic [AW-1:0]     addr0_i,
  output logic [DW-1:0]     q0_o,
  input  logic              we1_i,
  input  logic [AW-1:0]     addr1_i,
  input  logic [DW-1:0]     d1_i,
  input  logic [DW/8-1:0]   be1_i
);
  logic [DW-1:0] r_mem [SZ];
  logic [DW-1:0] r_q;

  // Output register only updates when enabled, so read data holds between reads.
  always_ff @(posedge clk_i) begin
    if (en0_i) begin
      r_q <= r_mem[addr0_i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we1_i && be1_i[b]) begin
        r_mem[addr1_i][b*8 +: 8] <= d1_i[b*8 +: 8];
      end
    end
  end

  assign q0_o = r_q;
endmodule

// File: rtl/pi1_bram_slave.sv
// rtl/pi1_bram_slave.sv - PI1 responder on a dual-port block RAM (WR/RD/RW swap)
//
// Purpose: terminates a PI1 master port on block RAM, with optional wait states.
// Ports: clk_i (rising edge), rst_i (async, active high),
//        pi1 (pi1_bram_slave_if.slave: op/addr/data/sel in, data/rdy out).
module pi1_bram_slave
  import pi1_bram_slave_pkg::*;
#(
  parameter int ARCHBITSZ  = 32,
  parameter int SZ         = 1024,
  parameter int WAITCYCLES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pi1_bram_slave_if.slave pi1
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int AW        = $clog2(SZ);
  localparam int CNTW      = cnt_width(WAITCYCLES);
  localparam int LOAD_I    = (WAITCYCLES > 0) ? WAITCYCLES - 1 : 0;
  localparam logic [CNTW-1:0] CNT_LOAD = LOAD_I[CNTW-1:0];
  localparam bit   HAS_WAIT = (WAITCYCLES > 0);

  state_e                r_state;
  logic                  r_rdy;
  logic                  r_rdvalid;
  logic [CNTW-1:0]       r_cnt;
  logic [AW-1:0]         r_addr;
  logic [ARCHBITSZ-1:0]  r_data;
  logic [SELBITSZ-1:0]   r_sel;

  logic [AW-1:0]         w_addr;
  logic                  w_accept;
  logic                  w_is_wr;
  logic                  w_is_rw;
  logic                  w_rd_en;
  logic [ARCHBITSZ-1:0]  w_ram_q;
  logic [ARCHBITSZ-1:0]  w_selmask;
  logic [ARCHBITSZ-1:0]  w_merge;
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [ARCHBITSZ-1:0]  w_wdata;
  logic [SELBITSZ-1:0]   w_wbe;

  // Only the low address bits select a word; the rest alias.
  assign w_addr   = pi1.pi1_addr_i[AW-1:0];
  generate
    if (ADDRBITSZ > AW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^pi1.pi1_addr_i[ADDRBITSZ-1:AW];
    end
  endgenerate

  assign w_accept = r_rdy && (pi1.pi1_op_i != PINOOP);
  assign w_is_wr  = w_accept && (pi1.pi1_op_i == PIWROP);
  assign w_is_rw  = w_accept && (pi1.pi1_op_i == PIRWOP);
  assign w_rd_en  = w_accept && ((pi1.pi1_op_i == PIRDOP) || (pi1.pi1_op_i == PIRWOP));

  generate
    for (genvar g = 0; g < SELBITSZ; g++) begin : g_mask
      assign w_selmask[g*8 +: 8] = {8{r_sel[g]}};
    end
  endgenerate

  // Swap write-back: held write data on selected bytes, old word elsewhere.
  assign w_merge = (r_data & w_selmask) | (w_ram_q & ~w_selmask);

  // Write port: plain WR writes straight from the bus at the accept edge;
  // the RMW cycle writes the merged word to the held address one edge later.
  // The two never coincide because rdy is low during RMW.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_addr;
    w_wdata = pi1.pi1_data_i;
    w_wbe   = pi1.pi1_sel_i;
    if (r_state == ST_RMW) begin
      w_we    = 1'b1;
      w_waddr = r_addr;
      w_wdata = w_merge;
      w_wbe   = '1;
    end else if (w_is_wr) begin
      w_we    = 1'b1;
    end
  end

  pi1_bram_slave_bram #(
    .DW (ARCHBITSZ),
    .SZ (SZ),
    .AW (AW)
  ) u_bram (
    .clk_i   (clk_i),
    .en0_i   (w_rd_en),
    .addr0_i (w_addr),
    .q0_o    (w_ram_q),
    .we1_i   (w_we),
    .addr1_i (w_waddr),
    .d1_i    (w_wdata),
    .be1_i   (w_wbe)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_rdy     <= 1'b1;
      r_rdvalid <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_sel     <= '0;
    end else begin
      if (w_rd_en) begin
        r_rdvalid <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= w_addr;
            r_data <= pi1.pi1_data_i;
            r_sel  <= pi1.pi1_sel_i;
            if (w_is_rw) begin
              r_state <= ST_RMW;
              r_rdy   <= 1'b0;
            end else if (HAS_WAIT) begin
              r_state <= ST_WAIT;
              r_rdy   <= 1'b0;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_RMW: begin
          if (HAS_WAIT) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_state <= ST_IDLE;
            r_rdy   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_rdy   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign pi1.pi1_data_o = r_rdvalid ? w_ram_q : '0;
  assign pi1.pi1_rdy_o  = r_rdy;
endmodule

// File: tb/tb_pi1_bram_slave.sv
// tb/tb_pi1_bram_slave.sv - directed self-checking bench for pi1_bram_slave
module tb_pi1_bram_slave;
  import pi1_bram_slave_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pi1_bram_slave_if #(.ARCHBITSZ(32)) bus0 ();
  pi1_bram_slave_if #(.ARCHBITSZ(32)) bus1 ();
  pi1_bram_slave_if #(.ARCHBITSZ(32)) bus2 ();

  pi1_bram_slave #(.ARCHBITSZ(32), .SZ(1024), .WAITCYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .pi1(bus0));
  pi1_bram_slave #(.ARCHBITSZ(32), .SZ(1024), .WAITCYCLES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .pi1(bus1));
  pi1_bram_slave #(.ARCHBITSZ(32), .SZ(16), .WAITCYCLES(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .pi1(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    bus0.pi1_op_i = op; bus0.pi1_addr_i = a; bus0.pi1_data_i = d; bus0.pi1_sel_i = s;
  endtask
  task automatic drv1(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    bus1.pi1_op_i = op; bus1.pi1_addr_i = a; bus1.pi1_data_i = d; bus1.pi1_sel_i = s;
  endtask
  task automatic drv2(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    bus2.pi1_op_i = op; bus2.pi1_addr_i = a; bus2.pi1_data_i = d; bus2.pi1_sel_i = s;
  endtask

  // Counts cycles with rdy low on dut1, bounded so a stuck rdy cannot hang.
  task automatic count_low1(output int n);
    n = 0;
    while (bus1.pi1_rdy_o !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy: got %b exp 1", bus0.pi1_rdy_o);
    end
    n_checks++;
    if (bus0.pi1_data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h exp 00000000", bus0.pi1_data_o);
    end
    n_checks++;
    if (bus1.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_rdy_w3: got %b exp 1", bus1.pi1_rdy_o);
    end
  endtask

  task automatic test_write_read;
    drv0(PIWROP, 30'd5, 32'hDEADBEEF, 4'b1111);
    tick();
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL t1_wr_rdy: got %b exp 1", bus0.pi1_rdy_o);
    end
    drv0(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus0.pi1_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t1_rd_data: got %h exp deadbeef", bus0.pi1_data_o);
    end
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL t1_rd_rdy: got %b exp 1", bus0.pi1_rdy_o);
    end
  endtask

  task automatic test_byte_sel;
    drv0(PIWROP, 30'd5, 32'h000000AA, 4'b0001);
    tick();
    drv0(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus0.pi1_data_o !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL t2_sel0001: got %h exp deadbeaa", bus0.pi1_data_o);
    end
    drv0(PIWROP, 30'd5, 32'h11111111, 4'b0000);
    tick();
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL t2_sel0000_rdy: got %b exp 1", bus0.pi1_rdy_o);
    end
    drv0(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus0.pi1_data_o !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL t2_sel0000_data: got %h exp deadbeaa", bus0.pi1_data_o);
    end
  endtask

  task automatic test_swap;
    drv0(PIRWOP, 30'd5, 32'h12345678, 4'b1111);
    tick();
    // Scramble the bus during RMW; the held copy must be what is written.
    drv0(PINOOP, 30'd7, 32'hFFFFFFFF, 4'b0000);
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b0) begin
      n_fail++; $display("FAIL t3_rmw_rdy: got %b exp 0", bus0.pi1_rdy_o);
    end
    n_checks++;
    if (bus0.pi1_data_o !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL t3_rmw_old: got %h exp deadbeaa", bus0.pi1_data_o);
    end
    tick();
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL t3_after_rdy: got %b exp 1", bus0.pi1_rdy_o);
    end
    n_checks++;
    if (bus0.pi1_data_o !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL t3_after_old: got %h exp deadbeaa", bus0.pi1_data_o);
    end
    drv0(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus0.pi1_data_o !== 32'h12345678) begin
      n_fail++; $display("FAIL t3_new_word: got %h exp 12345678", bus0.pi1_data_o);
    end
  endtask

  task automatic test_reset_in_rmw;
    drv0(PIRWOP, 30'd5, 32'h0BADF00D, 4'b1111);
    tick();
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b0) begin
      n_fail++; $display("FAIL t5_rmw_rdy: got %b exp 0", bus0.pi1_rdy_o);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus0.pi1_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL t5_rst_rdy: got %b exp 1", bus0.pi1_rdy_o);
    end
    n_checks++;
    if (bus0.pi1_data_o !== 32'h0) begin
      n_fail++; $display("FAIL t5_rst_data: got %h exp 00000000", bus0.pi1_data_o);
    end
    #1 rst = 1'b0;
    drv0(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus0.pi1_data_o !== 32'h12345678) begin
      n_fail++; $display("FAIL t5_no_write: got %h exp 12345678", bus0.pi1_data_o);
    end
  endtask

  task automatic test_wait_states;
    int n;
    drv1(PIWROP, 30'd5, 32'hDEADBEEF, 4'b1111);
    tick();
    drv1(PINOOP, 30'd0, 32'h0, 4'b0000);
    count_low1(n);
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL t4_wr_wait: got %0d cycles exp 3", n);
    end
    drv1(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    n = 0;
    while (bus1.pi1_rdy_o !== 1'b1 && n < 20) begin
      n_checks++;
      if (bus1.pi1_data_o !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL t4_wait_data: cycle %0d got %h exp deadbeef", n, bus1.pi1_data_o);
      end
      drv1((n % 2) ? PIRWOP : PIWROP, 30'd5, 32'h0, 4'b1111);
      n++;
      tick();
    end
    drv1(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (n != 3) begin
      n_fail++; $display("FAIL t4_rd_wait: got %0d cycles exp 3", n);
    end
    n_checks++;
    if (bus1.pi1_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t4_rd_data: got %h exp deadbeef", bus1.pi1_data_o);
    end
    drv1(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv1(PINOOP, 30'd0, 32'h0, 4'b0000);
    count_low1(n);
    n_checks++;
    if (bus1.pi1_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t4_ignored_inputs: got %h exp deadbeef", bus1.pi1_data_o);
    end
    drv1(PIWROP, 30'd5, 32'h00000055, 4'b1111);
    tick();
    drv1(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus1.pi1_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t4_wr_hold_data: got %h exp deadbeef", bus1.pi1_data_o);
    end
    count_low1(n);
    n_checks++;
    if (bus1.pi1_data_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t4_wr_hold_end: got %h exp deadbeef", bus1.pi1_data_o);
    end
    drv1(PIRDOP, 30'd5, 32'h0, 4'b0000);
    tick();
    drv1(PINOOP, 30'd0, 32'h0, 4'b0000);
    count_low1(n);
    n_checks++;
    if (bus1.pi1_data_o !== 32'h00000055) begin
      n_fail++; $display("FAIL t4_wr_landed: got %h exp 00000055", bus1.pi1_data_o);
    end
  endtask

  task automatic test_alias;
    drv2(PIWROP, 30'h15, 32'hCAFEF00D, 4'b1111);
    tick();
    drv2(PIRDOP, 30'h05, 32'h0, 4'b0000);
    tick();
    drv2(PINOOP, 30'd0, 32'h0, 4'b0000);
    n_checks++;
    if (bus2.pi1_data_o !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL t6_alias: got %h exp cafef00d", bus2.pi1_data_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_v;
    for (int i = 0; i < 3; i++) begin
      drv2(PIWROP, 30'(i), 32'h100 + 32'(i), 4'b1111);
      tick();
    end
    drv2(PIRDOP, 30'd0, 32'h0, 4'b0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drv2(PIRDOP, 30'(i + 1), 32'h0, 4'b0000);
      else       drv2(PINOOP, 30'd0, 32'h0, 4'b0000);
      exp_v = 32'h100 + 32'(i);
      n_checks++;
      if (bus2.pi1_data_o !== exp_v || bus2.pi1_rdy_o !== 1'b1) begin
        n_fail++; $display("FAIL t6_b2b_%0d: got %h rdy %b exp %h rdy 1", i, bus2.pi1_data_o, bus2.pi1_rdy_o, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drv0(PINOOP, 30'd0, 32'h0, 4'b0000);
    drv1(PINOOP, 30'd0, 32'h0, 4'b0000);
    drv2(PINOOP, 30'd0, 32'h0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_write_read();
    test_byte_sel();
    test_swap();
    test_reset_in_rmw();
    test_wait_states();
    test_alias();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
